axis_slave_if: RTL
==================

# axis_slave_if

AXI4-Stream slave front end of the FFT accelerator's input path. Accepts a frame of `S_TDATA_WDT`-bit beats from the PS-side DMA and packs `BPW = VLW_WDT/S_TDATA_WDT` consecutive beats, first beat in the MSBs, into one `VLW_WDT` word. It writes those words sequentially into the inputs memory. It mirrors the output-side master interface, so that a frame streamed out and back in round-trips bit-exact.

## Interface
- `S_TDATA_WDT`, 32: AXI stream data width; must divide `VLW_WDT`.
- `VLW_WDT`, 128: memory word width.
- `INPUT_MEM_SIZE`, 64: words per frame.
- `INPUT_MEM_ADDR_WDT`, 7: memory address width.
- `INPUT_MEM_OFFSET`, 0: first write address.
- `clk` in 1: the only clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `S_AXIS_TDATA` in `S_TDATA_WDT`: stream data.
- `S_AXIS_TVALID` in 1: stream valid.
- `S_AXIS_TLAST` in 1: last beat of frame.
- `S_AXIS_TREADY` out 1: slave ready.
- `inputs_ext_mem_addr` out `INPUT_MEM_ADDR_WDT`: write address.
- `inputs_ext_mem_data` out `VLW_WDT`: write data.
- `inputs_ext_mem_we` out 1: write request.
- `inputs_ext_mem_ready` in 1: memory accepts the write this cycle.
- `inputs_rx_start` in 1: one-cycle pulse that arms reception.
- `inputs_rx_busy` out 1: FSM not in IDLE.
- `inputs_rx_done` out 1: one-cycle pulse when the frame is fully written.
- `inputs_rx_err` out 1: sticky TLAST mismatch flag; cleared by the next `inputs_rx_start`.

## Operation
- **Beat acceptance:** a beat is accepted when `S_AXIS_TVALID & S_AXIS_TREADY`.
- **FSM `S_IDLE`:**
  - `inputs_rx_start` moves to `S_RECV`.
  - On entry to `S_RECV`: beat counter = 0, word counter = 0, address = `INPUT_MEM_OFFSET`, err = 0.
- **FSM `S_RECV`:**
  - Accepted beats shift into the pack register (new beat enters the LSBs and older beats move toward the MSBs), and the beat counter increments.
  - **Word completion.** On the beat with beat counter = `BPW-1`:
    - the completed word goes to the write register;
    - `inputs_ext_mem_we` is set;
    - the beat counter wraps to 0.
- **Write handshake:**
  - `inputs_ext_mem_we` holds, with stable data and address, until `inputs_ext_mem_ready`.
  - On acceptance, the address increments by 1 and the word counter increments by 1.
- **Backpressure.** `S_AXIS_TREADY = S_RECV & !(we & !inputs_ext_mem_ready & beat_cnt == BPW-1)`.
  - The pack register keeps collecting while a write is pending.
  - It stalls only when it would overwrite the pending word.
- **Normal end.** TLAST on the beat completing word `INPUT_MEM_SIZE-1` moves to `S_DRAIN`.
- **Early TLAST** (frame short):
  - remaining beats of the current word are zero-filled (LSBs);
  - the partial word is written;
  - err = 1;
  - FSM goes to `S_DRAIN`.
- **Missing TLAST** (final word complete, TLAST = 0):
  - err = 1;
  - FSM goes to `S_DRAIN`;
  - further beats are not accepted by this block.
- **FSM `S_DRAIN`:** waits for the last write to be accepted, then pulses `inputs_rx_done` and returns to `S_IDLE`.
- **Restart:** `inputs_rx_start` outside `S_IDLE` is ignored.

## Timing
- **Reset values:**
  - `S_AXIS_TREADY` = 0, `inputs_ext_mem_we` = 0;
  - `inputs_ext_mem_addr` = `INPUT_MEM_OFFSET`, `inputs_ext_mem_data` = 0;
  - `inputs_rx_busy` = 0, `inputs_rx_done` = 0, `inputs_rx_err` = 0;
  - FSM = `S_IDLE`.
- **Reset mid-frame:** aborts immediately with no done pulse. Memory contents already written are left as is.
- **Start:** `S_AXIS_TREADY` rises the cycle after `inputs_rx_start`.
- **Write latency:** `inputs_ext_mem_we` asserts the cycle after the word-completing beat. With `inputs_ext_mem_ready` tied high, the write completes in that same cycle.
- **Throughput:** with ready high, one beat per cycle sustained and no bubbles between words.
- **Done timing:** `inputs_rx_done` rises the cycle after the final write is accepted. It is a single-cycle pulse, and `inputs_rx_busy` falls in that same cycle.
- **Simultaneous events:** a write acceptance and a new word completion in the same cycle load the next word with no gap.
- **Address width:** the address increments modulo 2^`INPUT_MEM_ADDR_WDT`; the frame never wraps it when `OFFSET + SIZE <= 2^W`.

## Structure
- `axi_stream_pckg` holds:
  - `S_TDATA_WDT`, `VLW_WDT`, `INPUT_MEM_SIZE`, `INPUT_MEM_OFFSET`, `INPUT_MEM_ADDR_WDT`;
  - derived `BPW`;
  - the `s_rx_state` enum (`S_IDLE`, `S_RECV`, `S_DRAIN`).
- Natural sub-module: `axis_word_packer`, containing the pack shift register, beat counter and zero-fill on flush. The top level holds the FSM, write handshake and address generator.
- Assertions (simulation only):
  - no TREADY outside `S_RECV`;
  - `we` data stable while `!ready`;
  - exactly `INPUT_MEM_SIZE` writes per frame.

## Test plan
- **Nominal frame:** `BPW` = 4, 256 beats with values 0..255, TLAST on beat 255, ready = 1 → 64 writes to addresses 0..63. Word 0 = `{0,1,2,3}` MSB-first, done pulse 1 cycle after the last write, err = 0.
- **Memory stall:** same frame, `inputs_ext_mem_ready` low 5 cycles on word 10 → TREADY drops after 3 further beats, no data lost, address and data stable during the stall.
- **Early TLAST:** TLAST on beat 101 → word 25 = `{100,101,0,0}`, 26 writes, err = 1, done pulses.
- **Missing TLAST:** 260 beats, no TLAST → 64 writes, err = 1, TREADY = 0 after beat 255.
- **Random TVALID gaps:** random TVALID gaps and random ready, 50% duty → contents match reference packing. A second back-to-back start clears err and restarts at `INPUT_MEM_OFFSET`.
- **Reset mid-frame:** `rst_n` pulsed low mid-frame (word 30) → all outputs at reset values asynchronously, no done pulse. A new start receives a full frame correctly.

Source files
------------

// File: rtl/axis_slave_if_pkg.sv
// Shared constants and receive-FSM state type for the FFT accelerator's AXI-Stream input path.
package axi_stream_pckg;
    localparam int S_TDATA_WDT        = 32;
    localparam int VLW_WDT            = 128;
    localparam int INPUT_MEM_SIZE     = 64;
    localparam int INPUT_MEM_ADDR_WDT = 7;
    localparam int INPUT_MEM_OFFSET   = 0;

    localparam int BPW          = VLW_WDT / S_TDATA_WDT;
    localparam int BEAT_CNT_WDT = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WORD_CNT_WDT = $clog2(INPUT_MEM_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN
    } s_rx_state;
endpackage

// File: rtl/axis_slave_if_word_packer.sv
// Packs consecutive stream beats MSB-first into memory words, zero-filling a word cut short by TLAST.
module axis_word_packer
    import axi_stream_pckg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   accept,
    input  logic                   last,
    input  logic                   hold,
    input  logic                   take,
    input  logic [S_TDATA_WDT-1:0] data,
    output logic                   beat_last,
    output logic [VLW_WDT-1:0]     packed_word,
    output logic                   held,
    output logic [VLW_WDT-1:0]     held_word
);
    logic [VLW_WDT-1:0]      pack_reg;
    logic [VLW_WDT-1:0]      shifted;
    logic [BEAT_CNT_WDT-1:0] beat_cnt;

    assign beat_last = beat_cnt == BEAT_CNT_WDT'(BPW - 1);
    assign shifted   = (pack_reg << S_TDATA_WDT) | VLW_WDT'(data);
    // Left-align the beats gathered so far; older junk falls off the top, missing beats read as zero.
    assign packed_word = shifted << ((BPW - 1 - int'(beat_cnt)) * S_TDATA_WDT);
    assign held_word   = pack_reg;

    // A flushed word that cannot enter the busy write slot is parked in the pack register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg <= '0;
            beat_cnt <= '0;
            held     <= 1'b0;
        end else if (clear) begin
            pack_reg <= '0;
            beat_cnt <= '0;
            held     <= 1'b0;
        end else begin
            if (take) begin
                held <= 1'b0;
            end
            if (accept) begin
                if (hold) begin
                    pack_reg <= packed_word;
                    held     <= 1'b1;
                end else begin
                    pack_reg <= shifted;
                end
                if (beat_last || last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/axis_slave_if.sv
// AXI-Stream slave front end: receives one frame, packs beats into words and writes them to the inputs memory.
module axis_slave_if
    import axi_stream_pckg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_TDATA_WDT-1:0]        S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TLAST,
    output logic                          S_AXIS_TREADY,
    output logic [INPUT_MEM_ADDR_WDT-1:0] inputs_ext_mem_addr,
    output logic [VLW_WDT-1:0]            inputs_ext_mem_data,
    output logic                          inputs_ext_mem_we,
    input  logic                          inputs_ext_mem_ready,
    input  logic                          inputs_rx_start,
    output logic                          inputs_rx_busy,
    output logic                          inputs_rx_done,
    output logic                          inputs_rx_err
);
    s_rx_state                state, state_next;
    logic                     accept, beat_last, slot_free, write_accept;
    logic                     complete, flush_early, final_word, frame_end;
    logic                     arm, held, hold_flush, load_held, drain_last;
    logic [VLW_WDT-1:0]       packed_word, held_word;
    logic [WORD_CNT_WDT-1:0]  word_cnt, packed_cnt;

    assign accept       = S_AXIS_TVALID & S_AXIS_TREADY;
    assign write_accept = inputs_ext_mem_we & inputs_ext_mem_ready;
    assign slot_free    = !inputs_ext_mem_we | inputs_ext_mem_ready;
    assign complete     = accept & beat_last;
    assign flush_early  = accept & S_AXIS_TLAST & !beat_last;
    assign final_word   = packed_cnt == WORD_CNT_WDT'(INPUT_MEM_SIZE - 1);
    assign frame_end    = (complete & (final_word | S_AXIS_TLAST)) | flush_early;
    assign arm          = (state == S_IDLE) & inputs_rx_start;
    assign hold_flush   = flush_early & !slot_free;
    assign load_held    = (state == S_DRAIN) & held & slot_free;
    assign drain_last   = (state == S_DRAIN) & !held & write_accept;

    axis_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (arm),
        .accept      (accept),
        .last        (S_AXIS_TLAST),
        .hold        (hold_flush),
        .take        (load_held),
        .data        (S_AXIS_TDATA),
        .beat_last   (beat_last),
        .packed_word (packed_word),
        .held        (held),
        .held_word   (held_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (inputs_rx_start) state_next = S_RECV;
            S_RECV:  if (frame_end)       state_next = S_DRAIN;
            S_DRAIN: if (drain_last)      state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Beats keep flowing while a write is pending; only the beat that would overwrite it is stalled.
    always_comb begin
        S_AXIS_TREADY  = 1'b0;
        inputs_rx_busy = state != S_IDLE;
        if (state == S_RECV) begin
            S_AXIS_TREADY = !(inputs_ext_mem_we & !inputs_ext_mem_ready & beat_last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inputs_ext_mem_we   <= 1'b0;
            inputs_ext_mem_data <= '0;
            inputs_ext_mem_addr <= INPUT_MEM_ADDR_WDT'(INPUT_MEM_OFFSET);
            inputs_rx_done      <= 1'b0;
            inputs_rx_err       <= 1'b0;
            word_cnt            <= '0;
            packed_cnt          <= '0;
        end else begin
            inputs_rx_done <= drain_last;
            if (arm) begin
                inputs_ext_mem_addr <= INPUT_MEM_ADDR_WDT'(INPUT_MEM_OFFSET);
                inputs_rx_err       <= 1'b0;
                word_cnt            <= '0;
                packed_cnt          <= '0;
            end else begin
                if (write_accept) begin
                    inputs_ext_mem_we   <= 1'b0;
                    inputs_ext_mem_addr <= inputs_ext_mem_addr + 1'b1;
                    word_cnt            <= word_cnt + 1'b1;
                end
                if (complete || (flush_early && slot_free)) begin
                    inputs_ext_mem_data <= packed_word;
                    inputs_ext_mem_we   <= 1'b1;
                end else if (load_held) begin
                    inputs_ext_mem_data <= held_word;
                    inputs_ext_mem_we   <= 1'b1;
                end
                if (complete || flush_early) begin
                    packed_cnt <= packed_cnt + 1'b1;
                end
                if (flush_early || (complete && (S_AXIS_TLAST != final_word))) begin
                    inputs_rx_err <= 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_ready_only_in_recv: assert property (@(posedge clk) disable iff (!rst_n)
        S_AXIS_TREADY |-> state == S_RECV);
    a_write_stable: assert property (@(posedge clk) disable iff (!rst_n)
        inputs_ext_mem_we && !inputs_ext_mem_ready |=>
            inputs_ext_mem_we && $stable(inputs_ext_mem_data) && $stable(inputs_ext_mem_addr));
    a_full_frame_writes: assert property (@(posedge clk) disable iff (!rst_n)
        inputs_rx_done && !inputs_rx_err |-> word_cnt == WORD_CNT_WDT'(INPUT_MEM_SIZE));
`endif
endmodule
